// File: rtl/frame_info_pack_pkg.sv
// rtl/frame_info_pack_pkg.sv - shared word indices, FSM/segment encodings and shadow layouts
package frame_info_pack_pkg;

  localparam int SHORT_FLD_WD = 16;
  localparam int REG_FLD_WD   = 32;
  localparam int LONG_FLD_WD  = 64;
  localparam int CHUNK_FLD_WD = 5;

  // INFO segment word indices
  localparam int W_BLOCKID  = 0;
  localparam int W_TSTAMP   = 1;
  localparam int W_WIDTH    = 2;
  localparam int W_HEIGHT   = 3;
  localparam int W_OFFSET   = 4;
  localparam int W_SIZE     = 5;
  localparam int W_INTERVAL = 6;
  localparam int W_STATUS   = 7;
  // STATIS segment word indices
  localparam int W_PAYLOAD  = 0;
  localparam int W_SSTATUS  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SEG_INFO   = 1'b0,
    SEG_STATIS = 1'b1
  } seg_e;

  typedef struct packed {
    logic [LONG_FLD_WD-1:0]  block_id;
    logic [LONG_FLD_WD-1:0]  timestamp;
    logic [REG_FLD_WD-1:0]   pixel_format;
    logic [SHORT_FLD_WD-1:0] width;
    logic [SHORT_FLD_WD-1:0] height;
    logic [SHORT_FLD_WD-1:0] offset_x;
    logic [SHORT_FLD_WD-1:0] offset_y;
    logic [CHUNK_FLD_WD-1:0] chunk_info;
    logic [REG_FLD_WD-1:0]   image_size;
    logic [REG_FLD_WD-1:0]   payload_size;
    logic [LONG_FLD_WD-1:0]  frame_interval;
    logic [SHORT_FLD_WD-1:0] status;
  } info_shadow_t;

  typedef struct packed {
    logic [REG_FLD_WD-1:0]   expect_size;
    logic [REG_FLD_WD-1:0]   valid_size;
    logic [SHORT_FLD_WD-1:0] status;
  } statis_shadow_t;

  // ceil(log2(v)), minimum 1
  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_info_pack_word_mux.sv
// rtl/frame_info_pack_word_mux.sv - selects the 64-bit segment word from the shadow registers
module frame_info_word_mux
  import frame_info_pack_pkg::*;
#(
  parameter int CNT_WD = 6
) (
  input  seg_e              i_seg,
  input  logic [CNT_WD-1:0] iv_word_idx,
  input  info_shadow_t      i_info,
  input  statis_shadow_t    i_statis,
  output logic [63:0]       ov_word
);

  always_comb begin
    ov_word = '0;
    if (i_seg == SEG_INFO) begin
      case (iv_word_idx)
        CNT_WD'(W_BLOCKID):  ov_word = i_info.block_id;
        CNT_WD'(W_TSTAMP):   ov_word = i_info.timestamp;
        CNT_WD'(W_WIDTH):    ov_word = {16'b0, i_info.width, i_info.pixel_format};
        CNT_WD'(W_HEIGHT):   ov_word = {16'b0, i_info.offset_x, 16'b0, i_info.height};
        CNT_WD'(W_OFFSET):   ov_word = {16'b0, 11'b0, i_info.chunk_info, 16'b0, i_info.offset_y};
        CNT_WD'(W_SIZE):     ov_word = {i_info.payload_size, i_info.image_size};
        CNT_WD'(W_INTERVAL): ov_word = i_info.frame_interval;
        CNT_WD'(W_STATUS):   ov_word = {48'b0, i_info.status};
        default:             ov_word = '0;
      endcase
    end else begin
      case (iv_word_idx)
        CNT_WD'(W_PAYLOAD):  ov_word = {i_statis.valid_size, i_statis.expect_size};
        CNT_WD'(W_SSTATUS):  ov_word = {48'b0, i_statis.status};
        default:             ov_word = '0;
      endcase
    end
  end

endmodule

// File: rtl/frame_info_pack.sv
// rtl/frame_info_pack.sv - snapshots frame info/statistics and emits INFO and STATIS segments
module frame_info_pack
  import frame_info_pack_pkg::*;
#(
  parameter int INFO_SIZE    = 256,
  parameter int STATIS_SIZE  = 256,
  parameter int SHORT_REG_WD = 16,
  parameter int REG_WD       = 32,
  parameter int LONG_REG_WD  = 64,
  parameter int GEV_DE_WD    = 2,
  parameter int GEV_DATA_WD  = 64,
  parameter int SEG_GAP      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_stream_enable,
  input  logic                    i_frame_start,
  input  logic                    i_frame_end,
  input  logic                    i_ready,
  input  logic [LONG_REG_WD-1:0]  iv_block_id,
  input  logic [LONG_REG_WD-1:0]  iv_timestamp,
  input  logic [REG_WD-1:0]       iv_pixel_format,
  input  logic [SHORT_REG_WD-1:0] iv_width,
  input  logic [SHORT_REG_WD-1:0] iv_height,
  input  logic [SHORT_REG_WD-1:0] iv_offset_x,
  input  logic [SHORT_REG_WD-1:0] iv_offset_y,
  input  logic [4:0]              iv_chunk_info,
  input  logic [REG_WD-1:0]       iv_image_size,
  input  logic [REG_WD-1:0]       iv_payload_size,
  input  logic [LONG_REG_WD-1:0]  iv_frame_interval,
  input  logic [SHORT_REG_WD-1:0] iv_status,
  input  logic [REG_WD-1:0]       iv_expect_payload_size,
  input  logic [REG_WD-1:0]       iv_valid_payload_size,
  output logic                    o_info_flag,
  output logic                    o_statis_flag,
  output logic [GEV_DE_WD-1:0]    ov_dval,
  output logic [GEV_DATA_WD-1:0]  ov_cmd_data,
  output logic                    o_info_drop,
  output logic                    o_statis_drop
);

  localparam int INFO_WORDS   = INFO_SIZE / 8;
  localparam int STATIS_WORDS = STATIS_SIZE / 8;
  localparam int MAX_WORDS    = (INFO_WORDS > STATIS_WORDS) ? INFO_WORDS : STATIS_WORDS;
  localparam int CNT_WD       = log2(MAX_WORDS + 1);
  localparam int GAP_WD       = log2(SEG_GAP);

  state_e               r_state, w_state_nxt;
  seg_e                 r_seg, w_seg_nxt, w_sel_seg, w_mux_seg;
  logic [CNT_WD-1:0]    r_wcnt, w_wcnt_nxt, w_mux_idx, w_n_words;
  logic [GAP_WD-1:0]    r_gap, w_gap_nxt;
  logic                 r_info_pend, w_info_pend_nxt, r_statis_pend, w_statis_pend_nxt;
  logic                 r_info_flag, w_info_flag_nxt, r_statis_flag, w_statis_flag_nxt;
  logic                 r_info_drop, w_info_drop_nxt, r_statis_drop, w_statis_drop_nxt;
  logic [GEV_DE_WD-1:0] r_dval, w_dval_nxt;
  logic [GEV_DATA_WD-1:0] r_data, w_data_nxt;
  info_shadow_t         r_info_sh, w_info_sh_nxt;
  statis_shadow_t       r_statis_sh, w_statis_sh_nxt;
  logic [63:0]          w_word;
  logic                 w_info_busy, w_statis_busy;

  assign w_info_busy   = r_info_pend   || (r_state == ST_SEND && r_seg == SEG_INFO);
  assign w_statis_busy = r_statis_pend || (r_state == ST_SEND && r_seg == SEG_STATIS);
  // statistics belong to the older frame, so they go out first
  assign w_sel_seg = r_statis_pend ? SEG_STATIS : SEG_INFO;
  assign w_mux_seg = (r_state == ST_IDLE) ? w_sel_seg : r_seg;
  assign w_mux_idx = (r_state == ST_IDLE) ? '0 : r_wcnt;
  assign w_n_words = (r_seg == SEG_INFO) ? CNT_WD'(INFO_WORDS) : CNT_WD'(STATIS_WORDS);

  frame_info_word_mux #(.CNT_WD(CNT_WD)) u_word_mux (
    .i_seg       (w_mux_seg),
    .iv_word_idx (w_mux_idx),
    .i_info      (r_info_sh),
    .i_statis    (r_statis_sh),
    .ov_word     (w_word)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_seg_nxt         = r_seg;
    w_wcnt_nxt        = r_wcnt;
    w_gap_nxt         = r_gap;
    w_info_pend_nxt   = r_info_pend;
    w_statis_pend_nxt = r_statis_pend;
    w_info_flag_nxt   = r_info_flag;
    w_statis_flag_nxt = r_statis_flag;
    w_info_drop_nxt   = 1'b0;
    w_statis_drop_nxt = 1'b0;
    w_dval_nxt        = '0;
    w_data_nxt        = r_data;
    w_info_sh_nxt     = r_info_sh;
    w_statis_sh_nxt   = r_statis_sh;
    if (!i_stream_enable) begin
      w_state_nxt       = ST_IDLE;
      w_wcnt_nxt        = '0;
      w_gap_nxt         = '0;
      w_info_pend_nxt   = 1'b0;
      w_statis_pend_nxt = 1'b0;
      w_info_flag_nxt   = 1'b0;
      w_statis_flag_nxt = 1'b0;
      w_data_nxt        = '0;
    end else begin
      if (i_frame_start) begin
        if (w_info_busy) begin
          w_info_drop_nxt = 1'b1;
        end else begin
          w_info_pend_nxt              = 1'b1;
          w_info_sh_nxt.block_id       = iv_block_id;
          w_info_sh_nxt.timestamp      = iv_timestamp;
          w_info_sh_nxt.pixel_format   = iv_pixel_format;
          w_info_sh_nxt.width          = iv_width;
          w_info_sh_nxt.height         = iv_height;
          w_info_sh_nxt.offset_x       = iv_offset_x;
          w_info_sh_nxt.offset_y       = iv_offset_y;
          w_info_sh_nxt.chunk_info     = iv_chunk_info;
          w_info_sh_nxt.image_size     = iv_image_size;
          w_info_sh_nxt.payload_size   = iv_payload_size;
          w_info_sh_nxt.frame_interval = iv_frame_interval;
          w_info_sh_nxt.status         = iv_status;
        end
      end
      if (i_frame_end) begin
        if (w_statis_busy) begin
          w_statis_drop_nxt = 1'b1;
        end else begin
          w_statis_pend_nxt           = 1'b1;
          w_statis_sh_nxt.expect_size = iv_expect_payload_size;
          w_statis_sh_nxt.valid_size  = iv_valid_payload_size;
          w_statis_sh_nxt.status      = iv_status;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (r_info_pend || r_statis_pend) begin
            w_state_nxt = ST_SEND;
            w_seg_nxt   = w_sel_seg;
            if (w_sel_seg == SEG_STATIS) begin
              w_statis_pend_nxt = 1'b0;
              w_statis_flag_nxt = 1'b1;
            end else begin
              w_info_pend_nxt = 1'b0;
              w_info_flag_nxt = 1'b1;
            end
            // word 0 can already leave together with the rising flag
            if (i_ready) begin
              w_dval_nxt = '1;
              w_data_nxt = w_word;
              w_wcnt_nxt = CNT_WD'(1);
            end else begin
              w_wcnt_nxt = '0;
            end
          end
        end
        ST_SEND: begin
          if (r_wcnt == w_n_words) begin
            w_state_nxt       = ST_GAP;
            w_info_flag_nxt   = 1'b0;
            w_statis_flag_nxt = 1'b0;
            w_gap_nxt         = '0;
          end else if (i_ready) begin
            w_dval_nxt = '1;
            w_data_nxt = w_word;
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_WD'(SEG_GAP - 1)) w_state_nxt = ST_IDLE;
          else                               w_gap_nxt   = r_gap + 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_seg         <= SEG_INFO;
      r_wcnt        <= '0;
      r_gap         <= '0;
      r_info_pend   <= 1'b0;
      r_statis_pend <= 1'b0;
      r_info_flag   <= 1'b0;
      r_statis_flag <= 1'b0;
      r_info_drop   <= 1'b0;
      r_statis_drop <= 1'b0;
      r_dval        <= '0;
      r_data        <= '0;
      r_info_sh     <= '0;
      r_statis_sh   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_seg         <= w_seg_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_gap         <= w_gap_nxt;
      r_info_pend   <= w_info_pend_nxt;
      r_statis_pend <= w_statis_pend_nxt;
      r_info_flag   <= w_info_flag_nxt;
      r_statis_flag <= w_statis_flag_nxt;
      r_info_drop   <= w_info_drop_nxt;
      r_statis_drop <= w_statis_drop_nxt;
      r_dval        <= w_dval_nxt;
      r_data        <= w_data_nxt;
      r_info_sh     <= w_info_sh_nxt;
      r_statis_sh   <= w_statis_sh_nxt;
    end
  end

  assign o_info_flag   = r_info_flag;
  assign o_statis_flag = r_statis_flag;
  assign ov_dval       = r_dval;
  assign ov_cmd_data   = r_data;
  assign o_info_drop   = r_info_drop;
  assign o_statis_drop = r_statis_drop;

endmodule
